// File: rtl/arith_pkg.sv
// Shared encodings and constants for the sequential multiplier/divider datapath.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        JUDGE  = 2'b01,
        SHIFT  = 2'b10,
        FINISH = 2'b11
    } state_t;

    // Quotient reported for a zero divisor; sliced down to the operand width.
    localparam logic [31:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtraction for one restoring-division step: compares and subtracts in WIDTH+1 bits.
module div_trial_sub #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] dvs,
    output logic             ge,
    output logic [WIDTH:0]   diff
);

    logic [WIDTH:0] dvs_ext;

    assign dvs_ext = {1'b0, dvs};
    assign ge      = (rem >= dvs_ext);
    assign diff    = rem - dvs_ext;

endmodule

// File: rtl/unsigned_divider.sv
// Sequential restoring divider: q = x / y, r = x % y, one quotient bit per SHIFT/JUDGE pair.
module unsigned_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             done,
    output logic             busy,
    output logic             dbz
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             dbz_pend;
    logic             trial_ge;
    logic [WIDTH:0]   trial_diff;

    div_trial_sub #(.WIDTH(WIDTH)) u_trial (
        .rem  (rem),
        .dvs  (dvs),
        .ge   (trial_ge),
        .diff (trial_diff)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = (y == '0) ? FINISH : SHIFT;
            SHIFT:   state_nxt = JUDGE;
            JUDGE:   state_nxt = (cnt == CNT_LAST) ? FINISH : SHIFT;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            dbz_pend <= 1'b0;
            q        <= '0;
            r        <= '0;
            dbz      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        if (y != '0) begin
                            rem <= '0;
                            quo <= x;
                            dvs <= y;
                            cnt <= '0;
                        end else begin
                            // Zero divisor skips iteration: remainder is the dividend itself.
                            rem      <= {1'b0, x};
                            quo      <= DBZ_QUOTIENT[WIDTH-1:0];
                            dbz_pend <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    {rem, quo} <= {rem[WIDTH-1:0], quo, 1'b0};
                end
                JUDGE: begin
                    if (trial_ge) begin
                        rem    <= trial_diff;
                        quo[0] <= 1'b1;
                    end
                    cnt <= cnt + CW'(1);
                end
                FINISH: begin
                    q        <= quo;
                    r        <= rem[WIDTH-1:0];
                    dbz      <= dbz_pend;
                    dbz_pend <= 1'b0;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unsigned_divider.sv
// Scoreboard bench for unsigned_divider (WIDTH=4) against a behavioural / and % model.
module tb_unsigned_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         done;
    logic         busy;
    logic         dbz;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int unsigned cyc = 0;
    int unsigned last_done = 0;
    bit          have_last = 0;
    bit          b2b = 0;

    unsigned_divider #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .x    (x),
        .y    (y),
        .q    (q),
        .r    (r),
        .done (done),
        .busy (busy),
        .dbz  (dbz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Result monitor: every done pops one expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check($sformatf("q %0d/%0d", mon_e.a, mon_e.b), q, mon_e.q);
                    check($sformatf("r %0d/%0d", mon_e.a, mon_e.b), r, mon_e.r);
                    check($sformatf("dbz %0d/%0d", mon_e.a, mon_e.b), dbz, mon_e.dbz);
                    if (b2b && have_last)
                        check($sformatf("spacing %0d/%0d", mon_e.a, mon_e.b), cyc - last_done,
                              mon_e.dbz ? 2 : 2 * W + 2);
                end
                last_done = cyc;
                have_last = 1'b1;
            end
        end
    end

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        if (done === 1'b1) seen = 1'b1;
        check("done_timeout", seen, 1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int lat_exp);
        int unsigned t0;
        bit seen;
        @(negedge clk);
        en = 1'b1;
        x  = a;
        y  = b;
        sb.push_back(model(a, b));
        t0 = cyc;
        @(negedge clk);
        en = 1'b0;
        check("busy_after_accept", busy, 1);
        wait_done(seen);
        if (seen) check($sformatf("latency %0d/%0d", a, b), cyc - t0, lat_exp);
        check("busy_at_done", busy, 0);
    endtask

    initial begin
        int d0;
        bit seen;
        rst = 1'b1;
        en  = 1'b0;
        x   = '0;
        y   = '0;
        repeat (2) @(negedge clk);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_dbz", dbz, 0);
        rst = 1'b0;

        // Basic operation, zero divisor, then normal divide after dbz.
        run_op(4'd13, 4'd3, 2 * W + 2);
        run_op(4'd7, 4'd0, 2);
        run_op(4'd6, 4'd2, 2 * W + 2);

        // Corner values.
        run_op(4'd2, 4'd9, 2 * W + 2);
        run_op(4'd15, 4'd1, 2 * W + 2);
        run_op(4'd15, 4'd15, 2 * W + 2);
        run_op(4'd0, 4'd5, 2 * W + 2);

        // Start request and operand changes while busy must be ignored.
        d0 = done_cnt;
        @(negedge clk);
        en = 1'b1; x = 4'd11; y = 4'd2;
        sb.push_back(model(4'd11, 4'd2));
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b1; x = 4'd1; y = 4'd1;
        @(negedge clk);
        en = 1'b0; x = 4'd7; y = 4'd3;
        wait_done(seen);
        repeat (14) @(negedge clk);
        check("single_done", done_cnt - d0, 1);

        // Reset in the middle of an operation aborts it.
        d0 = done_cnt;
        @(negedge clk);
        en = 1'b1; x = 4'd12; y = 4'd5;
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_q", q, 0);
        check("abort_r", r, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dbz", dbz, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        run_op(4'd9, 4'd2, 2 * W + 2);

        // All operand pairs back-to-back with en held high.
        @(negedge clk);
        have_last = 1'b0;
        b2b = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 20 && busy; k++) @(negedge clk);
            if (busy) begin
                check("b2b_idle_timeout", busy, 0);
                break;
            end
            x = 4'(i >> 4);
            y = 4'(i);
            sb.push_back(model(x, y));
            @(negedge clk);
        end
        en = 1'b0;
        for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge clk);
        check("b2b_drained", sb.size(), 0);
        b2b = 1'b0;

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
